// File: rtl/airlock_sequencer_pkg.sv
// rtl/airlock_sequencer_pkg.sv - shared state codes and defaults for the airlock sequencer
// Purpose: state encoding (4-bit, fixed codes shown on the debug display)
//          and the default door-close timeout.
package airlock_sequencer_pkg;

    localparam int DOOR_TO_CYCLES_DEFAULT = 1000;
    localparam int STATE_W                = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IN_READY  = 4'd0,
        ST_IN_OPEN   = 4'd1,
        ST_IN_CLOSE  = 4'd2,
        ST_EVAC      = 4'd3,
        ST_OUT_READY = 4'd4,
        ST_OUT_OPEN  = 4'd5,
        ST_OUT_CLOSE = 4'd6,
        ST_PRESS     = 4'd7,
        ST_FAULT     = 4'd8
    } state_e;

endpackage

// File: rtl/airlock_sequencer_door_watchdog.sv
// rtl/airlock_sequencer_door_watchdog.sv - saturating door-close watchdog
// Purpose: counts cycles while a door is commanded closed but not yet sensed
//          closed; flags a timeout when the count reaches LIMIT.
// Ports:   clock, reset (async active-low)
//          en      - count this cycle (door is in its closing state)
//          clear   - zero the counter (owner state is changing)
//          timeout - combinational: this cycle's increment reaches LIMIT
module airlock_sequencer_door_watchdog #(
    parameter int LIMIT = 1000,
    parameter int WD_W  = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic timeout
);

    logic [WD_W-1:0] count_q;
    logic [WD_W-1:0] count_d;

    localparam logic [WD_W:0] LIMIT_W = (WD_W + 1)'(LIMIT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != {WD_W{1'b1}})) begin
            // Saturate at all-ones so a long stall can never wrap back to zero.
            count_d = count_q + 1'b1;
        end
    end

    // Fires in the cycle whose increment would make the count equal LIMIT,
    // so the owner leaves the closing state exactly LIMIT cycles after entry.
    assign timeout = en && (({1'b0, count_q} + 1'b1) >= LIMIT_W);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/airlock_sequencer.sv
// rtl/airlock_sequencer.sv - two-door airlock interlock sequencer (Moore FSM)
// Purpose: sequences inner/outer doors and evac/press pumps so both doors are
//          never open together and no door opens before the chamber settles.
// Ports:   clock, reset (async active-low)
//          req_in, req_out          - level open requests (inner / outer door)
//          inner_closed, outer_closed - door sensors, 1 = fully closed
//          timer_done               - sticky settle-timer done
//          timer_clear              - 1 holds the settle timer cleared
//          open_inner, open_outer   - door open commands
//          pump_evac, pump_press    - chamber pumps
//          fault                    - latched interlock fault
//          state                    - current state code
module airlock_sequencer
    import airlock_sequencer_pkg::*;
#(
    parameter int DOOR_TO_CYCLES = DOOR_TO_CYCLES_DEFAULT,
    parameter int WD_W           = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_in,
    input  logic               req_out,
    input  logic               inner_closed,
    input  logic               outer_closed,
    input  logic               timer_done,
    output logic               timer_clear,
    output logic               open_inner,
    output logic               open_outer,
    output logic               pump_evac,
    output logic               pump_press,
    output logic               fault,
    output logic [STATE_W-1:0] state
);

    state_e state_q, state_d;
    logic   first_q, first_d;
    logic   state_change;
    logic   in_timeout, out_timeout;
    logic   both_closed;

    assign both_closed  = inner_closed && outer_closed;
    assign state_change = (state_d != state_q);
    // Marks the first cycle spent in a state; timer_done may still be high
    // from the previous transit then, before timer_clear has taken effect.
    assign first_d      = state_change;

    airlock_sequencer_door_watchdog #(
        .LIMIT (DOOR_TO_CYCLES),
        .WD_W  (WD_W)
    ) u_wd_inner (
        .clock   (clock),
        .reset   (reset),
        .en      (state_q == ST_IN_CLOSE),
        .clear   (state_change),
        .timeout (in_timeout)
    );

    airlock_sequencer_door_watchdog #(
        .LIMIT (DOOR_TO_CYCLES),
        .WD_W  (WD_W)
    ) u_wd_outer (
        .clock   (clock),
        .reset   (reset),
        .en      (state_q == ST_OUT_CLOSE),
        .clear   (state_change),
        .timeout (out_timeout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IN_READY: begin
                if (req_in) begin
                    state_d = ST_IN_OPEN;
                end else if (req_out && both_closed) begin
                    state_d = ST_EVAC;
                end
            end
            ST_IN_OPEN: begin
                if (!req_in) state_d = ST_IN_CLOSE;
            end
            ST_IN_CLOSE: begin
                if (inner_closed) begin
                    state_d = ST_IN_READY;
                end else if (in_timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_EVAC: begin
                // A breach outranks completion; requests are ignored mid-cycle.
                if (!both_closed) begin
                    state_d = ST_FAULT;
                end else if (timer_done && !first_q) begin
                    state_d = ST_OUT_READY;
                end
            end
            ST_OUT_READY: begin
                if (req_out) begin
                    state_d = ST_OUT_OPEN;
                end else if (req_in && both_closed) begin
                    state_d = ST_PRESS;
                end
            end
            ST_OUT_OPEN: begin
                if (!req_out) state_d = ST_OUT_CLOSE;
            end
            ST_OUT_CLOSE: begin
                if (outer_closed) begin
                    state_d = ST_OUT_READY;
                end else if (out_timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_PRESS: begin
                if (!both_closed) begin
                    state_d = ST_FAULT;
                end else if (timer_done && !first_q) begin
                    state_d = ST_IN_READY;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // Outputs depend on registered state only.
    always_comb begin
        timer_clear = 1'b1;
        open_inner  = 1'b0;
        open_outer  = 1'b0;
        pump_evac   = 1'b0;
        pump_press  = 1'b0;
        fault       = 1'b0;
        case (state_q)
            ST_IN_OPEN:  open_inner = 1'b1;
            ST_OUT_OPEN: open_outer = 1'b1;
            ST_EVAC: begin
                pump_evac   = 1'b1;
                timer_clear = 1'b0;
            end
            ST_PRESS: begin
                pump_press  = 1'b1;
                timer_clear = 1'b0;
            end
            ST_FAULT:    fault = 1'b1;
            default: begin
                timer_clear = 1'b1;
            end
        endcase
    end

    assign state = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IN_READY;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_airlock_sequencer.sv
// tb/tb_airlock_sequencer.sv - self-checking bench for airlock_sequencer
module tb_airlock_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req_in = 1'b0, req_out = 1'b0;
    logic       inner_closed = 1'b1, outer_closed = 1'b1;
    logic       timer_done;
    logic       timer_clear, open_inner, open_outer, pump_evac, pump_press, fault;
    logic [3:0] state;

    logic       use_model = 1'b0;
    logic       td_drv = 1'b0;
    int         tmr_cnt = 0;
    logic       model_done;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    // Settle timer model: counts while not cleared, done sticky after 50 steps.
    always @(posedge clock) begin
        if (timer_clear) tmr_cnt <= 0;
        else if (tmr_cnt < 50) tmr_cnt <= tmr_cnt + 1;
    end
    assign model_done = (tmr_cnt >= 50);
    assign timer_done = use_model ? model_done : td_drv;

    airlock_sequencer #(.DOOR_TO_CYCLES(8), .WD_W(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_in       (req_in),
        .req_out      (req_out),
        .inner_closed (inner_closed),
        .outer_closed (outer_closed),
        .timer_done   (timer_done),
        .timer_clear  (timer_clear),
        .open_inner   (open_inner),
        .open_outer   (open_outer),
        .pump_evac    (pump_evac),
        .pump_press   (pump_press),
        .fault        (fault),
        .state        (state)
    );

    // Interlock invariants, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset) begin
            n_vec++;
            if ((open_inner && open_outer) || (pump_evac && pump_press) ||
                ((open_inner || open_outer) && (pump_evac || pump_press))) begin
                n_fail++;
                $display("FAIL invariant: oi=%0b oo=%0b ev=%0b pr=%0b", open_inner, open_outer,
                         pump_evac, pump_press);
            end
        end
    end

    // Expected {timer_clear, open_inner, open_outer, pump_evac, pump_press, fault}
    function automatic logic [5:0] exp_outs(input int s);
        case (s)
            1:       return 6'b110000;
            3:       return 6'b000100;
            5:       return 6'b101000;
            7:       return 6'b000010;
            8:       return 6'b100001;
            default: return 6'b100000;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input int exp);
        check({name, ".state"}, int'(state), exp);
        check({name, ".outs"},
              int'({timer_clear, open_inner, open_outer, pump_evac, pump_press, fault}),
              int'(exp_outs(exp)));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        req_in = 0; req_out = 0; inner_closed = 1; outer_closed = 1;
        td_drv = 0; use_model = 0;
        reset = 0;
        tick();
        reset = 1;
    endtask

    task automatic wait_state(input string name, input int exp, input int max_cyc);
        int k;
        k = 0;
        while (int'(state) != exp && k < max_cyc) begin
            tick();
            k++;
        end
        check({name, ".reached"}, int'(state), exp);
    endtask

    typedef struct {
        logic ri, ro, ic, oc, td;
        int   exp_state;
    } vec_t;

    vec_t vecs[19];

    initial begin
        // ri ro ic oc td  -> state after the edge
        vecs[0]  = '{0, 0, 1, 1, 0, 0};  // idle
        vecs[1]  = '{1, 1, 1, 1, 0, 1};  // tie in IN_READY: req_in wins
        vecs[2]  = '{1, 0, 1, 1, 0, 1};  // hold open
        vecs[3]  = '{0, 0, 0, 1, 0, 2};  // release -> IN_CLOSE
        vecs[4]  = '{0, 0, 0, 1, 0, 2};  // still closing
        vecs[5]  = '{0, 0, 1, 1, 0, 0};  // closed -> IN_READY
        vecs[6]  = '{0, 1, 1, 1, 1, 3};  // req_out, stale done high -> EVAC
        vecs[7]  = '{0, 0, 1, 1, 1, 3};  // first EVAC cycle ignores done
        vecs[8]  = '{0, 0, 1, 1, 1, 4};  // done -> OUT_READY
        vecs[9]  = '{1, 1, 1, 1, 0, 5};  // tie in OUT_READY: req_out wins
        vecs[10] = '{0, 0, 1, 0, 0, 6};  // release -> OUT_CLOSE
        vecs[11] = '{0, 0, 1, 1, 0, 4};  // closed -> OUT_READY
        vecs[12] = '{1, 0, 1, 1, 0, 7};  // req_in -> PRESS
        vecs[13] = '{0, 0, 1, 1, 0, 7};
        vecs[14] = '{0, 0, 1, 1, 1, 0};  // done -> IN_READY
        vecs[15] = '{0, 1, 1, 1, 0, 3};  // EVAC again
        vecs[16] = '{0, 0, 0, 1, 0, 8};  // inner breach -> FAULT
        vecs[17] = '{1, 0, 1, 1, 0, 8};  // absorbing
        vecs[18] = '{0, 1, 1, 1, 1, 8};

        // Reset state, observed while reset is still asserted.
        reset = 0;
        #3;
        check_state("reset", 0);
        do_reset();

        for (int i = 0; i < 19; i++) begin
            req_in = vecs[i].ri; req_out = vecs[i].ro;
            inner_closed = vecs[i].ic; outer_closed = vecs[i].oc;
            td_drv = vecs[i].td;
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].exp_state);
        end

        // Door stuck in IN_CLOSE: fault exactly 8 cycles after entry.
        do_reset();
        req_in = 1; tick();
        req_in = 0; inner_closed = 0; tick();
        check_state("stuck.entry", 2);
        for (int c = 1; c < 8; c++) begin
            tick();
            check(.name($sformatf("stuck.c%0d", c)), .act(int'(state)), .exp(2));
        end
        tick();
        check_state("stuck.fault", 8);
        for (int c = 0; c < 4; c++) begin
            req_in = c[0]; req_out = ~c[0]; inner_closed = 1;
            tick();
            check(.name($sformatf("stuck.hold%0d", c)), .act(int'(fault)), .exp(1));
        end
        reset = 0; #1;
        check_state("stuck.reset", 0);
        reset = 1;

        // Breach during PRESS.
        do_reset();
        req_out = 1; tick();
        req_out = 0; td_drv = 1; tick(); tick();
        check_state("pbr.outready", 4);
        td_drv = 0; req_in = 1; tick();
        check_state("pbr.press", 7);
        req_in = 0; outer_closed = 0; tick();
        check_state("pbr.fault", 8);

        // Full outbound + inbound transit with the timer model.
        do_reset();
        use_model = 1;
        req_out = 1; tick();
        check_state("tr.evac", 3);
        req_out = 0;
        wait_state("tr.outready", 4, 70);
        req_out = 1; tick();
        check_state("tr.outopen", 5);
        req_out = 0; tick();
        check_state("tr.outclose", 6);
        tick();
        check_state("tr.outready2", 4);
        req_in = 1; tick();
        check_state("tr.press", 7);
        wait_state("tr.inready", 0, 70);
        tick();
        check_state("tr.inopen", 1);
        req_in = 0;

        // Async reset mid-EVAC with the timer around step 20.
        do_reset();
        use_model = 1;
        req_out = 1; tick();
        req_out = 0;
        for (int c = 0; c < 20; c++) tick();
        check_state("mid.evac", 3);
        #2;
        reset = 0;
        #1;
        check_state("mid.reset", 0);
        tick();
        reset = 1;
        tick();
        check_state("mid.after", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
